// File: rtl/aiq_multibank_pkg.sv
// Shared types and helpers for the multibank ALU issue queue.
//   AL_SIZE / NUM_PREGS : active-list and physical register file sizes.
//   aiq_entry_t         : one queued ALU micro-op with source tags and readiness.
//   al_in_window        : tests whether an AL index lies in a wrapping half-open window.
//   al_age              : age of an AL index relative to the oldest live entry.
package aiq_multibank_pkg;

    localparam int AL_SIZE   = 32;
    localparam int NUM_PREGS = 64;
    localparam int AL_W      = $clog2(AL_SIZE);
    localparam int PR_W      = $clog2(NUM_PREGS);

    typedef logic [AL_W-1:0] al_idx_t;
    typedef logic [PR_W-1:0] preg_t;

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SLT
    } aiq_op_e;

    typedef struct packed {
        aiq_op_e     op;
        al_idx_t     al_idx;
        preg_t       rd;
        preg_t       rs1_tag;
        preg_t       rs2_tag;
        logic        rs1_rdy;
        logic        rs2_rdy;
        logic [31:0] imm;
    } aiq_entry_t;

    // Window is [lo, hi) modulo AL_SIZE; lo == hi means nothing is flushed.
    function automatic logic al_in_window(al_idx_t idx, al_idx_t lo, al_idx_t hi);
        if (lo == hi)
            return 1'b0;
        else if (lo < hi)
            return (idx >= lo) && (idx < hi);
        else
            return (idx >= lo) || (idx < hi);
    endfunction

    // Wrap subtraction makes ages monotonic from the active-list back pointer.
    function automatic al_idx_t al_age(al_idx_t idx, al_idx_t back);
        return idx - back;
    endfunction

endpackage

// File: rtl/aiq_multibank_if.sv
// Bus bundle between rename/writeback/ALU side (master) and the issue queue (slave).
//   i_disp_valid/i_disp        : per-lane dispatch requests
//   if_recall/new_front/old_front/back : flush window and age base
//   i_wb_valid/i_wb_tag        : writeback tag broadcasts
//   o_iss_valid/o_iss/i_iss_ready : per-bank issue handshake
//   o_occupancy/o_bank_full    : per-bank fill status
interface aiq_multibank_if #(
    parameter int NUM_BANKS = 2,
    parameter int DEPTH     = 8,
    parameter int NUM_WB    = 4
);
    import aiq_multibank_pkg::*;

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic       [NUM_BANKS-1:0]            i_disp_valid;
    aiq_entry_t [NUM_BANKS-1:0]            i_disp;
    logic                                  if_recall;
    al_idx_t                               new_front;
    al_idx_t                               old_front;
    al_idx_t                               back;
    logic       [NUM_WB-1:0]               i_wb_valid;
    preg_t      [NUM_WB-1:0]               i_wb_tag;
    logic       [NUM_BANKS-1:0]            o_iss_valid;
    aiq_entry_t [NUM_BANKS-1:0]            o_iss;
    logic       [NUM_BANKS-1:0]            i_iss_ready;
    logic       [NUM_BANKS-1:0][OCC_W-1:0] o_occupancy;
    logic       [NUM_BANKS-1:0]            o_bank_full;

    modport master (
        output i_disp_valid, i_disp, if_recall, new_front, old_front, back,
               i_wb_valid, i_wb_tag, i_iss_ready,
        input  o_iss_valid, o_iss, o_occupancy, o_bank_full
    );

    modport slave (
        input  i_disp_valid, i_disp, if_recall, new_front, old_front, back,
               i_wb_valid, i_wb_tag, i_iss_ready,
        output o_iss_valid, o_iss, o_occupancy, o_bank_full
    );

endinterface

// File: rtl/aiq_multibank_bank.sv
// One issue-queue bank: entry array, writeback wakeup CAM, age-ordered select,
// a single registered issue slot and a registered occupancy count.
//   clk, reset (sync, active-low), extStall_i  : clocking and global freeze
//   dispValid_i/disp_i                         : one dispatch lane
//   recall_i/newFront_i/oldFront_i/back_i      : flush window and age base
//   wbValid_i/wbTag_i                          : writeback broadcasts
//   issValid_o/iss_o/issReady_i                : issue handshake
//   occupancy_o/bankFull_o                     : fill status
module aiq_bank_n
    import aiq_multibank_pkg::*;
#(
    parameter int  DEPTH  = 8,
    parameter int  NUM_WB = 4,
    localparam int OCC_W  = $clog2(DEPTH + 1),
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   extStall_i,
    input  logic                   dispValid_i,
    input  aiq_entry_t             disp_i,
    input  logic                   recall_i,
    input  al_idx_t                newFront_i,
    input  al_idx_t                oldFront_i,
    input  al_idx_t                back_i,
    input  logic      [NUM_WB-1:0] wbValid_i,
    input  preg_t     [NUM_WB-1:0] wbTag_i,
    input  logic                   issReady_i,
    output logic                   issValid_o,
    output aiq_entry_t             iss_o,
    output logic      [OCC_W-1:0]  occupancy_o,
    output logic                   bankFull_o
);

    aiq_entry_t             entries_q [DEPTH];
    aiq_entry_t             entries_d [DEPTH];
    aiq_entry_t             woken     [DEPTH];
    logic       [DEPTH-1:0] valid_q, valid_d, flush;
    aiq_entry_t             slot_q, slot_d;
    logic                   slotValid_q, slotValid_d;
    logic       [OCC_W-1:0] occ_q, occ_d;

    logic                   selFound, freeFound, dispFire, slotOpen;
    logic       [IDX_W-1:0] selIdx, freeIdx;
    al_idx_t                selAge;
    aiq_entry_t             dispWoken;

    // x0 never waits; otherwise a source is ready if already marked or broadcast now.
    function automatic logic srcReady(preg_t tag, logic rdy,
                                      logic [NUM_WB-1:0] wbV, preg_t [NUM_WB-1:0] wbT);
        logic hit;
        hit = rdy || (tag == '0);
        for (int w = 0; w < NUM_WB; w++)
            if (wbV[w] && (wbT[w] == tag))
                hit = 1'b1;
        return hit;
    endfunction

    assign bankFull_o  = (occ_q == OCC_W'(DEPTH));
    assign occupancy_o = occ_q;
    assign issValid_o  = slotValid_q;
    assign iss_o       = slot_q;

    // Wakeup merge, flush marking and oldest-ready selection. Selection sees
    // this cycle's broadcasts so a woken entry can load the slot at the same edge.
    always_comb begin
        flush    = '0;
        selFound = 1'b0;
        selIdx   = '0;
        selAge   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            woken[k]         = entries_q[k];
            woken[k].rs1_rdy = srcReady(entries_q[k].rs1_tag, entries_q[k].rs1_rdy, wbValid_i, wbTag_i);
            woken[k].rs2_rdy = srcReady(entries_q[k].rs2_tag, entries_q[k].rs2_rdy, wbValid_i, wbTag_i);
            flush[k] = recall_i && valid_q[k] &&
                       al_in_window(entries_q[k].al_idx, newFront_i, oldFront_i);
            if (valid_q[k] && !flush[k] && woken[k].rs1_rdy && woken[k].rs2_rdy) begin
                if (!selFound || (al_age(entries_q[k].al_idx, back_i) < selAge)) begin
                    selFound = 1'b1;
                    selIdx   = IDX_W'(k);
                    selAge   = al_age(entries_q[k].al_idx, back_i);
                end
            end
        end
    end

    // Next-state of array, slot and occupancy. The free slot is searched on the
    // registered valids, so a slot vacated this cycle is not reused until the next.
    always_comb begin
        entries_d   = woken;
        valid_d     = valid_q & ~flush;
        slot_d      = slot_q;
        slotValid_d = slotValid_q;
        freeFound   = 1'b0;
        freeIdx     = '0;
        dispWoken   = disp_i;
        occ_d       = '0;

        slotOpen = !extStall_i && (!slotValid_q || issReady_i);
        if (slotOpen) begin
            slotValid_d = selFound;
            slot_d      = woken[selIdx];
            if (selFound)
                valid_d[selIdx] = 1'b0;
        end else if (recall_i && slotValid_q &&
                     al_in_window(slot_q.al_idx, newFront_i, oldFront_i)) begin
            slotValid_d = 1'b0;
        end

        for (int k = 0; k < DEPTH; k++) begin
            if (!valid_q[k] && !freeFound) begin
                freeFound = 1'b1;
                freeIdx   = IDX_W'(k);
            end
        end
        dispFire = dispValid_i && !bankFull_o && !extStall_i && !recall_i && freeFound;
        dispWoken.rs1_rdy = srcReady(disp_i.rs1_tag, disp_i.rs1_rdy, wbValid_i, wbTag_i);
        dispWoken.rs2_rdy = srcReady(disp_i.rs2_tag, disp_i.rs2_rdy, wbValid_i, wbTag_i);
        if (dispFire) begin
            entries_d[freeIdx] = dispWoken;
            valid_d[freeIdx]   = 1'b1;
        end

        for (int k = 0; k < DEPTH; k++)
            occ_d = occ_d + OCC_W'(valid_d[k]);
    end

    // Entry payloads and slot contents need no reset; only the valid bits do.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q     <= '0;
            slotValid_q <= 1'b0;
            occ_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            slotValid_q <= slotValid_d;
            occ_q       <= occ_d;
            slot_q      <= slot_d;
            for (int k = 0; k < DEPTH; k++)
                entries_q[k] <= entries_d[k];
        end
    end

endmodule

// File: rtl/aiq_multibank.sv
// Parametrised ALU issue queue: NUM_BANKS independent banks, one rename lane
// and one issue port per bank, woken by NUM_WB writeback broadcasts.
//   clk, reset (sync, active-low), ext_stall : clocking and global freeze
//   bus (slave modport)                      : dispatch, recall, writeback, issue, status
//   int_stall                                : some lane requests dispatch into a full bank
module aiq_multibank
    import aiq_multibank_pkg::*;
#(
    parameter int NUM_BANKS = 2,
    parameter int DEPTH     = 8,
    parameter int NUM_WB    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ext_stall,
    aiq_multibank_if.slave        bus,
    output logic                  int_stall
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic       [NUM_BANKS-1:0]            issValid;
    aiq_entry_t [NUM_BANKS-1:0]            iss;
    logic       [NUM_BANKS-1:0][OCC_W-1:0] occ;
    logic       [NUM_BANKS-1:0]            bankFull;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : gBank
        aiq_bank_n #(
            .DEPTH  (DEPTH),
            .NUM_WB (NUM_WB)
        ) uBank (
            .clk         (clk),
            .reset       (reset),
            .extStall_i  (ext_stall),
            .dispValid_i (bus.i_disp_valid[b]),
            .disp_i      (bus.i_disp[b]),
            .recall_i    (bus.if_recall),
            .newFront_i  (bus.new_front),
            .oldFront_i  (bus.old_front),
            .back_i      (bus.back),
            .wbValid_i   (bus.i_wb_valid),
            .wbTag_i     (bus.i_wb_tag),
            .issReady_i  (bus.i_iss_ready[b]),
            .issValid_o  (issValid[b]),
            .iss_o       (iss[b]),
            .occupancy_o (occ[b]),
            .bankFull_o  (bankFull[b])
        );
    end

    assign bus.o_iss_valid = issValid;
    assign bus.o_iss       = iss;
    assign bus.o_occupancy = occ;
    assign bus.o_bank_full = bankFull;
    assign int_stall       = |(bankFull & bus.i_disp_valid);

endmodule
